pixel_readout_ctrl: RTL and testbench

//   Reading side of the pixel data bus. Sequences the per-row read strobes
//   (read1, read2, ...) into the pixel array/databus, captures the returned
//   16-bit binary pixel word once per row, and buffers it in a small FIFO.
//   The buffered words leave on a valid/ready stream to the downstream

---
 rtl/readout_pkg.sv | 23 ++
 rtl/readout_fifo.sv | 64 ++++++
 rtl/pixel_readout_ctrl.sv | 115 +++++++++++
 tb/tb_pixel_readout_ctrl.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/readout_pkg.sv
// Shared types for the pixel readout path: bus width, controller states and
// the FIFO entry layout that carries the end-of-frame marker with each word.
package readout_pkg;

   localparam int DATA_W = 16;

   typedef enum logic [1:0] {
      IDLE,
      READ,
      DONE
   } rd_state_t;

   typedef struct packed {
      logic              last;
      logic [DATA_W-1:0] data;
   } fifo_entry_t;

   // Row counter width; a single-row frame still needs one bit.
   function automatic int row_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/readout_fifo.sv
// Small synchronous FIFO for captured pixel words. The head entry is read
// combinationally so downstream sees it as soon as out_valid rises.
module readout_fifo
   import readout_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        push,
   input  fifo_entry_t wr_entry,
   input  logic        pop,
   output logic        full,
   output logic        empty,
   output fifo_entry_t head
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   fifo_entry_t        mem [DEPTH];
   logic [PTR_W-1:0]   wr_ptr_reg;
   logic [PTR_W-1:0]   rd_ptr_reg;
   logic [CNT_W-1:0]   count_reg;
   logic [CNT_W-1:0]   count_next;
   logic               push_ok;
   logic               pop_ok;

   assign full    = (count_reg == CNT_W'(DEPTH));
   assign empty   = (count_reg == '0);
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;

   // Empty FIFO presents zero so out_data is clean after reset.
   assign head = empty ? '0 : mem[rd_ptr_reg];

   always_comb begin
      count_next = count_reg;
      case ({push_ok, pop_ok})
         2'b10:   count_next = count_reg + CNT_W'(1);
         2'b01:   count_next = count_reg - CNT_W'(1);
         default: count_next = count_reg;
      endcase
   end

   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr_reg] <= wr_entry;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push_ok) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
         if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
         count_reg <= count_next;
      end
   end

endmodule

// File: rtl/pixel_readout_ctrl.sv
// Row-read sequencer: strobes one row per cycle into the pixel databus,
// captures the returned word into a FIFO and streams it out valid/ready.
module pixel_readout_ctrl
   import readout_pkg::*;
#(
   parameter int NUM_ROWS   = 2,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic [DATA_W-1:0]   pix_data_in,
   output logic [NUM_ROWS-1:0] read_sel,
   output logic [DATA_W-1:0]   out_data,
   output logic                out_valid,
   input  logic                out_ready,
   output logic                out_last,
   output logic                busy,
   output logic                frame_done
);

   localparam int                ROW_W    = row_width(NUM_ROWS);
   localparam logic [ROW_W-1:0]  LAST_ROW = ROW_W'(NUM_ROWS - 1);

   rd_state_t            state_reg;
   rd_state_t            state_next;
   logic [ROW_W-1:0]     row_reg;
   logic [ROW_W-1:0]     row_next;
   logic [NUM_ROWS-1:0]  read_sel_reg;
   logic [NUM_ROWS-1:0]  read_sel_next;

   logic                 fifo_full;
   logic                 fifo_empty;
   logic                 push;
   logic                 pop;
   fifo_entry_t          wr_entry;
   fifo_entry_t          head;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg    <= IDLE;
         row_reg      <= '0;
         read_sel_reg <= '0;
      end else begin
         state_reg    <= state_next;
         row_reg      <= row_next;
         read_sel_reg <= read_sel_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      row_next   = row_reg;
      push       = 1'b0;
      wr_entry   = '{last: (row_reg == LAST_ROW), data: pix_data_in};
      case (state_reg)
         IDLE: begin
            if (start) begin
               state_next = READ;
               row_next   = '0;
            end
         end
         READ: begin
            // A full FIFO holds row and strobe until space opens up.
            if (!fifo_full) begin
               push = 1'b1;
               if (row_reg == LAST_ROW) begin
                  state_next = DONE;
                  row_next   = '0;
               end else begin
                  row_next = row_reg + ROW_W'(1);
               end
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
            row_next   = '0;
         end
      endcase
   end

   // Strobes are decoded from the next row so they are registered and one-hot.
   genvar gi;
   generate
      for (gi = 0; gi < NUM_ROWS; gi++) begin : g_sel
         assign read_sel_next[gi] = (state_next == READ) && (row_next == ROW_W'(gi));
      end
   endgenerate

   assign pop = out_valid && out_ready;

   readout_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .push     (push),
      .wr_entry (wr_entry),
      .pop      (pop),
      .full     (fifo_full),
      .empty    (fifo_empty),
      .head     (head)
   );

   assign read_sel   = read_sel_reg;
   assign out_valid  = !fifo_empty;
   assign out_data   = head.data;
   assign out_last   = head.last;
   assign busy       = (state_reg != IDLE);
   assign frame_done = (state_reg == DONE);

endmodule

// File: tb/tb_pixel_readout_ctrl.sv
// Bench for pixel_readout_ctrl: default build checked cycle by cycle against
// a queue-based frame model; 4-row and 1-row builds get directed sweeps.
module tb_pixel_readout_ctrl;

   localparam int DEPTH = 4;
   localparam int NROWS = 2;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic        out_ready = 1'b0;
   logic [15:0] pix = '0;
   logic [1:0]  read_sel;
   logic [15:0] out_data;
   logic        out_valid, out_last, busy, frame_done;

   logic        start4 = 1'b0;
   logic        ready4 = 1'b1;
   logic [3:0]  read_sel4;
   logic [15:0] out_data4;
   logic        out_valid4, out_last4, busy4, frame_done4;

   logic        start1 = 1'b0;
   logic        ready1 = 1'b1;
   logic [0:0]  read_sel1;
   logic [15:0] out_data1;
   logic        out_valid1, out_last1, busy1, frame_done1;

   int n_cmp = 0;
   int n_err = 0;

   // Frame model: phase 0 idle, 1 reading row m_row, 2 done; m_q = {last,data}
   int          m_phase = 0;
   int          m_row   = 0;
   logic [16:0] m_q [$];

   always #5 clk = ~clk;

   pixel_readout_ctrl #(.NUM_ROWS(NROWS), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .start(start), .pix_data_in(pix),
      .read_sel(read_sel), .out_data(out_data), .out_valid(out_valid),
      .out_ready(out_ready), .out_last(out_last), .busy(busy),
      .frame_done(frame_done)
   );

   pixel_readout_ctrl #(.NUM_ROWS(4), .FIFO_DEPTH(DEPTH)) dut4 (
      .clk(clk), .reset(reset), .start(start4), .pix_data_in(pix),
      .read_sel(read_sel4), .out_data(out_data4), .out_valid(out_valid4),
      .out_ready(ready4), .out_last(out_last4), .busy(busy4),
      .frame_done(frame_done4)
   );

   pixel_readout_ctrl #(.NUM_ROWS(1), .FIFO_DEPTH(DEPTH)) dut1 (
      .clk(clk), .reset(reset), .start(start1), .pix_data_in(pix),
      .read_sel(read_sel1), .out_data(out_data1), .out_valid(out_valid1),
      .out_ready(ready1), .out_last(out_last1), .busy(busy1),
      .frame_done(frame_done1)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_model();
      logic [16:0] h;
      h = (m_q.size() > 0) ? m_q[0] : 17'h0;
      check("read_sel",   32'(read_sel),   (m_phase == 1) ? 32'(1 << m_row) : 32'd0);
      check("out_valid",  32'(out_valid),  32'(m_q.size() > 0));
      check("out_data",   32'(out_data),   32'(h[15:0]));
      check("out_last",   32'(out_last),   32'(h[16]));
      check("busy",       32'(busy),       32'(m_phase != 0));
      check("frame_done", 32'(frame_done), 32'(m_phase == 2));
   endtask

   // Apply one clock with the inputs currently driven, advance the model, compare.
   task automatic tick();
      bit full_pre;
      full_pre = (m_q.size() == DEPTH);
      if (m_q.size() > 0 && out_ready) void'(m_q.pop_front());
      case (m_phase)
         0: if (start) begin m_phase = 1; m_row = 0; end
         1: if (!full_pre) begin
               m_q.push_back({logic'(m_row == NROWS - 1), pix});
               if (m_row == NROWS - 1) m_phase = 2;
               else m_row++;
            end
         default: m_phase = 0;
      endcase
      @(posedge clk);
      #1;
      check_model();
      $display("cycle t=%0t start=%b rdy=%b pix=%h sel=%b vld=%b data=%h last=%b busy=%b fd=%b",
               $time, start, out_ready, pix, read_sel, out_valid, out_data, out_last, busy, frame_done);
   endtask

   task automatic async_reset();
      @(negedge clk);
      reset = 1'b0;
      #1;
      m_q.delete();
      m_phase = 0;
      m_row   = 0;
      check("rst_read_sel",  32'(read_sel),  32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_busy",      32'(busy),      32'd0);
      check("rst_out_data",  32'(out_data),  32'd0);
      @(negedge clk);
      reset = 1'b1;
   endtask

   initial begin
      #60000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int frames;
      repeat (2) @(posedge clk);
      #1;
      check_model();
      check("rst_frame_done", 32'(frame_done), 32'd0);
      @(negedge clk);
      reset = 1'b1;

      // 1: single frame, known bus words
      out_ready = 1'b1;
      start = 1'b1; pix = 16'(urandom_word()); tick(); start = 1'b0;
      check("t1_sel_row0", 32'(read_sel), 32'h1);
      pix = 16'hA55A; tick();
      check("t1_sel_row1", 32'(read_sel), 32'h2);
      check("t1_word0", 32'(out_data), 32'hA55A);
      pix = 16'h1234; tick();
      check("t1_word1", 32'({out_last, out_data}), 32'h11234);
      check("t1_done", 32'(frame_done), 32'h1);
      tick();

      // 2: three frames back-to-back into a stalled output
      out_ready = 1'b0;
      frames = 0;
      for (int i = 0; i < 24; i++) begin
         start = (m_phase == 0 && frames < 3);
         if (start) frames++;
         pix = 16'(urandom_word());
         tick();
      end
      start = 1'b0;
      check("t2_stall_sel", 32'(read_sel), 32'h1);
      out_ready = 1'b1;
      for (int i = 0; i < 12; i++) begin pix = 16'(urandom_word()); tick(); end

      // 3: start during READ is ignored
      start = 1'b1; tick(); tick(); start = 1'b0;
      for (int i = 0; i < 5; i++) begin pix = 16'(urandom_word()); tick(); end

      // 4: reset in row 1 with one word buffered
      out_ready = 1'b0;
      start = 1'b1; tick(); start = 1'b0;
      pix = 16'hDEAD; tick();
      async_reset();
      out_ready = 1'b1;
      start = 1'b1; tick(); start = 1'b0;
      for (int i = 0; i < 5; i++) begin pix = 16'(urandom_word()); tick(); end

      // 5: full FIFO with ready high stalls one cycle
      out_ready = 1'b0;
      frames = 0;
      for (int i = 0; i < 10; i++) begin
         start = (m_phase == 0 && frames < 2);
         if (start) frames++;
         pix = 16'(urandom_word());
         tick();
      end
      start = 1'b1; tick(); start = 1'b0;
      tick();
      out_ready = 1'b1;
      tick();
      check("t5_stall_sel", 32'(read_sel), 32'h1);
      pix = 16'h5A5A; tick();
      check("t5_push_sel", 32'(read_sel), 32'h2);
      for (int i = 0; i < 8; i++) begin pix = 16'(urandom_word()); tick(); end

      // random traffic
      for (int i = 0; i < 400; i++) begin
         start     = ($urandom_range(0, 5) == 0);
         out_ready = ($urandom_range(0, 1) == 1);
         pix       = 16'(urandom_word());
         tick();
         if (i == 200) async_reset();
      end
      start = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) tick();

      // 6a: four-row build sweeps one-hot, last on the final row
      start4 = 1'b1; tick(); start4 = 1'b0;
      check("r4_sel0", 32'(read_sel4), 32'h1);
      check("r4_busy", 32'(busy4), 32'h1);
      for (int r = 0; r < 4; r++) begin
         pix = 16'(16'h1000 + r);
         tick();
         check("r4_sel",   32'(read_sel4),  (r < 3) ? 32'(1 << (r + 1)) : 32'd0);
         check("r4_valid", 32'(out_valid4), 32'h1);
         check("r4_data",  32'(out_data4),  32'(16'h1000 + r));
         check("r4_last",  32'(out_last4),  32'(r == 3));
         check("r4_done",  32'(frame_done4), 32'(r == 3));
      end
      tick();
      check("r4_drained", 32'({busy4, out_valid4}), 32'h0);

      // 6b: single-row build
      start1 = 1'b1; tick(); start1 = 1'b0;
      check("r1_sel", 32'(read_sel1), 32'h1);
      pix = 16'hBEEF; tick();
      check("r1_sel_off", 32'(read_sel1), 32'h0);
      check("r1_word", 32'({out_last1, out_data1}), 32'h1BEEF);
      check("r1_done", 32'(frame_done1), 32'h1);
      tick();
      check("r1_drained", 32'({busy1, out_valid1}), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   function automatic logic [31:0] urandom_word();
      return $urandom;
   endfunction

endmodule
